variable_logical_rightshift_seq: RTL

Multi-cycle variable logical right shifter: it accepts a WIDTH-bit operand and a shift amount over a valid/ready handshake. It applies one binary-weighted shift stage per cycle, largest stage first, and presents the zero-filled result on a held valid/ready output port. It is the right-shift counterpart of the combinational variable left shifter, and targets datapaths that trade latency for area: serial ALUs and decode/unpack paths.

---
 rtl/variable_logical_rightshift_seq_if.sv | 35 +++
 rtl/variable_logical_rightshift_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/variable_logical_rightshift_seq_if.sv
// Request/result bundle for the sequential logical right shifter.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request side and the result side.
//
// Signals (named from the shifter's point of view):
//   in_valid_i / in_ready_o  request handshake
//   val_i, shift_n_i         operand and shift amount, sampled on accept
//   out_valid_o / out_ready_i result handshake
//   result_o                 zero-filled val_i >> shift_n_i
//   busy_o                   a transaction is in flight (SHIFT or DONE)
interface variable_logical_rightshift_seq_if #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [WIDTH-1:0]   val_i;
  logic [SHIFT_W-1:0] shift_n_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [WIDTH-1:0]   result_o;
  logic               busy_o;

  // The shifter itself.
  modport slave (
    input  in_valid_i, val_i, shift_n_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, busy_o
  );

  // The requester/consumer driving the shifter.
  modport master (
    output in_valid_i, val_i, shift_n_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/variable_logical_rightshift_seq.sv
// Multi-cycle variable logical right shifter: one binary-weighted stage per cycle, largest first.
// Latency: SHIFT_W cycles from accept to out_valid_o; accepts spaced SHIFT_W+2 cycles apart at best.
// Backpressure: result held in DONE until out_ready_i; in_ready_o low while busy, no queuing.
//
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset (aborts any transaction in flight)
//   bus     slave side of variable_logical_rightshift_seq_if (request, result, busy)
module variable_logical_rightshift_seq #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  variable_logical_rightshift_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHIFT_W-1:0] amt_q, amt_d;
  logic [SHIFT_W-1:0] stage_q, stage_d;

  // Select amt_q[stage_q] by shifting rather than indexing, so the index
  // width never has to match the bit-select width of amt_q.
  logic [SHIFT_W-1:0] amt_shr;
  logic               stage_en;

  assign amt_shr  = amt_q >> stage_q;
  assign stage_en = amt_shr[0];

  // State register and datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    stage_d = stage_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          data_d  = bus.val_i;
          amt_d   = bus.shift_n_i;
          stage_d = SHIFT_W'(SHIFT_W - 1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Stage k moves the value by 2**k; the logical >> zero-fills the top.
        if (stage_en) begin
          data_d = data_q >> (1 << stage_q);
        end
        // Every stage is visited, even for a zero amount, so latency is fixed.
        if (stage_q == '0) begin
          state_d = DONE;
        end else begin
          stage_d = stage_q - SHIFT_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs are pure decodes of registered state.
  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.busy_o      = (state_q == SHIFT) || (state_q == DONE);
  assign bus.result_o    = data_q;

endmodule
